// File: rtl/uart_pkg.sv
// Shared types for the UART RX frame controller: parser states, error codes, default sync byte.
package uart_pkg;

   typedef enum logic [2:0] {
      S_SYNC,
      S_LEN,
      S_PAY,
      S_CHK,
      S_OUT
   } frm_state_t;

   typedef enum logic [1:0] {
      E_OVR = 2'd0,
      E_LEN = 2'd1,
      E_CHK = 2'd2,
      E_TMO = 2'd3
   } frm_err_t;

   localparam logic [7:0] C_SYNC_DEFAULT = 8'hA5;

   // Pointer width able to hold 0..maxlen inclusive.
   function automatic int unsigned frm_ptr_w(input int unsigned maxlen);
      return $clog2(maxlen + 1);
   endfunction

endpackage

// File: rtl/uart_frm_buf.sv
// Payload buffer for the frame controller: c_maxlen x 8 register array, one write port, async read.
module uart_frm_buf
   import uart_pkg::*;
#(
   parameter int unsigned c_maxlen = 16
) (
   input  logic                               clk_i,
   input  logic                               we_i,
   input  logic [frm_ptr_w(c_maxlen)-1:0]     waddr_i,
   input  logic [7:0]                         wdata_i,
   input  logic [frm_ptr_w(c_maxlen)-1:0]     raddr_i,
   output logic [7:0]                         rdata_o
);

   logic [7:0] r_mem [c_maxlen];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         r_mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: parses [SYNC][LEN][PAYLOAD][CHK], releases payload on valid/ready.
// Optional feature macro UART_FRM_STATS_EN adds good/error frame counters (good_cnt_o, err_cnt_o).
module uart_rx_frame_ctrl
   import uart_pkg::*;
#(
   parameter logic [7:0]  c_sync        = C_SYNC_DEFAULT,
   parameter int unsigned c_maxlen      = 16,
   parameter int unsigned c_timeout_cyc = 100_000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  rx_byte_i,
   input  logic        rx_valid_i,
   output logic [7:0]  frm_data_o,
   output logic        frm_valid_o,
   input  logic        frm_ready_i,
   output logic        frm_last_o,
   output logic [7:0]  frm_len_o,
   output logic        frm_err_o,
   output logic [1:0]  err_code_o,
`ifdef UART_FRM_STATS_EN
   output logic [15:0] good_cnt_o,
   output logic [15:0] err_cnt_o,
`endif
   output logic        busy_o
);

   localparam int unsigned PW         = frm_ptr_w(c_maxlen);
   localparam logic [7:0]  C_MAX8     = 8'(c_maxlen);
   localparam logic [31:0] C_TMO_LAST = 32'(c_timeout_cyc - 1);

   frm_state_t    r_state;
   frm_err_t      r_code;
   logic [7:0]    r_len;
   logic [7:0]    r_sum;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [31:0]   r_gap;
   logic          r_valid;
   logic [7:0]    r_data;
   logic          r_last;
   logic          r_err;

   logic          w_xfer;
   logic          w_we;
   logic [PW-1:0] w_rd_addr;
   logic [7:0]    w_rd_data;
   logic [7:0]    w_wr_pos;
   logic [7:0]    w_rd_pos;

   assign w_xfer   = r_valid && frm_ready_i;
   assign w_we     = (r_state == S_PAY) && rx_valid_i;
   assign w_wr_pos = 8'(r_wr_ptr);
   assign w_rd_pos = 8'(r_rd_ptr);

   // Read port looks one entry ahead so the next byte can be registered on each transfer.
   always_comb begin
      w_rd_addr = '0;
      if (r_state == S_OUT) begin
         w_rd_addr = r_last ? r_rd_ptr : r_rd_ptr + PW'(1);
      end
   end

   uart_frm_buf #(
      .c_maxlen (c_maxlen)
   ) u_buf (
      .clk_i   (clk_i),
      .we_i    (w_we),
      .waddr_i (r_wr_ptr),
      .wdata_i (rx_byte_i),
      .raddr_i (w_rd_addr),
      .rdata_o (w_rd_data)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_SYNC;
         r_code   <= E_OVR;
         r_len    <= '0;
         r_sum    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_gap    <= '0;
         r_valid  <= 1'b0;
         r_data   <= '0;
         r_last   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_err <= 1'b0;
         unique case (r_state)
            S_SYNC: begin
               r_gap <= '0;
               if (rx_valid_i && rx_byte_i == c_sync) begin
                  r_state <= S_LEN;
               end
            end

            S_LEN, S_PAY, S_CHK: begin
               // A strobe in the cycle the gap limit is reached takes priority over the timeout.
               if (rx_valid_i) begin
                  r_gap <= '0;
                  unique case (r_state)
                     S_LEN: begin
                        if (rx_byte_i == 8'd0 || rx_byte_i > C_MAX8) begin
                           r_err   <= 1'b1;
                           r_code  <= E_LEN;
                           r_state <= S_SYNC;
                        end else begin
                           r_len    <= rx_byte_i;
                           r_sum    <= rx_byte_i;
                           r_wr_ptr <= '0;
                           r_state  <= S_PAY;
                        end
                     end
                     S_PAY: begin
                        r_sum    <= r_sum + rx_byte_i;
                        r_wr_ptr <= r_wr_ptr + PW'(1);
                        if (w_wr_pos == r_len - 8'd1) begin
                           r_state <= S_CHK;
                        end
                     end
                     default: begin
                        if (rx_byte_i == r_sum) begin
                           r_rd_ptr <= '0;
                           r_valid  <= 1'b1;
                           r_data   <= w_rd_data;
                           r_last   <= (r_len == 8'd1);
                           r_state  <= S_OUT;
                        end else begin
                           r_err   <= 1'b1;
                           r_code  <= E_CHK;
                           r_state <= S_SYNC;
                        end
                     end
                  endcase
               end else if (r_gap == C_TMO_LAST) begin
                  r_gap   <= '0;
                  r_err   <= 1'b1;
                  r_code  <= E_TMO;
                  r_state <= S_SYNC;
               end else begin
                  r_gap <= r_gap + 32'd1;
               end
            end

            S_OUT: begin
               r_gap <= '0;
               if (rx_valid_i) begin
                  r_err  <= 1'b1;
                  r_code <= E_OVR;
               end
               if (w_xfer) begin
                  if (r_last) begin
                     r_valid <= 1'b0;
                     r_last  <= 1'b0;
                     r_data  <= '0;
                     r_state <= S_SYNC;
                  end else begin
                     r_rd_ptr <= r_rd_ptr + PW'(1);
                     r_data   <= w_rd_data;
                     r_last   <= (w_rd_pos + 8'd2 == r_len);
                  end
               end
            end

            default: r_state <= S_SYNC;
         endcase
      end
   end

   assign frm_data_o  = r_data;
   assign frm_valid_o = r_valid;
   assign frm_last_o  = r_last;
   assign frm_len_o   = r_len;
   assign frm_err_o   = r_err;
   assign err_code_o  = r_code;
   assign busy_o      = (r_state != S_SYNC);

`ifdef UART_FRM_STATS_EN
   logic [15:0] r_good_cnt;
   logic [15:0] r_err_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_good_cnt <= '0;
         r_err_cnt  <= '0;
      end else begin
         if (w_xfer && r_last && r_good_cnt != '1) begin
            r_good_cnt <= r_good_cnt + 16'd1;
         end
         if (r_err && r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
      end
   end

   assign good_cnt_o = r_good_cnt;
   assign err_cnt_o  = r_err_cnt;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed frames plus random frames against a frame-level model.
module tb_uart_rx_frame_ctrl;

   localparam int unsigned T      = 200;
   localparam int unsigned MAXLEN = 16;
   localparam logic [1:0]  C_OVR  = 2'd0;
   localparam logic [1:0]  C_LEN  = 2'd1;
   localparam logic [1:0]  C_CHK  = 2'd2;
   localparam logic [1:0]  C_TMO  = 2'd3;

   typedef struct {
      logic [7:0] d;
      logic       last;
      logic [7:0] len;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_byte = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  frm_data;
   logic        frm_valid;
   logic        frm_ready = 1'b0;
   logic        frm_last;
   logic [7:0]  frm_len;
   logic        frm_err;
   logic [1:0]  err_code;
   logic        busy;
`ifdef UART_FRM_STATS_EN
   logic [15:0] good_cnt;
   logic [15:0] err_cnt;
`endif

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   int unsigned n_unexp = 0;
   int unsigned cyc     = 0;
   int unsigned last_strobe_cyc = 0;
   int unsigned last_err_cyc    = 0;
   logic        hold_ready = 1'b0;
   logic        prev_stall = 1'b0;
   logic        prev_last_xfer = 1'b0;
   logic [7:0]  prev_data = '0;

   exp_t        exp_q[$];
   logic [1:0]  err_q[$];

   uart_rx_frame_ctrl #(
      .c_sync        (8'hA5),
      .c_maxlen      (MAXLEN),
      .c_timeout_cyc (T)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .rx_byte_i   (rx_byte),
      .rx_valid_i  (rx_valid),
      .frm_data_o  (frm_data),
      .frm_valid_o (frm_valid),
      .frm_ready_i (frm_ready),
      .frm_last_o  (frm_last),
      .frm_len_o   (frm_len),
      .frm_err_o   (frm_err),
      .err_code_o  (err_code),
`ifdef UART_FRM_STATS_EN
      .good_cnt_o  (good_cnt),
      .err_cnt_o   (err_cnt),
`endif
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      frm_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // Frame-level reference: outcome follows from LEN range and the modulo-256 sum alone.
   function automatic void model_frame(input logic [7:0] fq[$]);
      int unsigned len;
      int unsigned s;
      exp_t        e;
      len = int'(fq[1]);
      if (len == 0 || len > MAXLEN) begin
         err_q.push_back(C_LEN);
         return;
      end
      s = len;
      for (int i = 0; i < int'(len); i++) s += int'(fq[2 + i]);
      if (fq[2 + len] == 8'(s % 256)) begin
         for (int i = 0; i < int'(len); i++) begin
            e.d    = fq[2 + i];
            e.last = (i == int'(len) - 1);
            e.len  = 8'(len);
            exp_q.push_back(e);
         end
      end else begin
         err_q.push_back(C_CHK);
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_stall     = 1'b0;
         prev_last_xfer = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_data", frm_data, prev_data);
            check("hold_valid", frm_valid, 1);
         end
         if (prev_last_xfer) check("valid_after_last", frm_valid, 0);
         prev_stall     = frm_valid && !frm_ready;
         prev_data      = frm_data;
         prev_last_xfer = 1'b0;
         if (frm_valid && frm_ready) begin
            if (exp_q.size() == 0) begin
               n_unexp++;
            end else begin
               e = exp_q.pop_front();
               check("data", frm_data, e.d);
               check("last", frm_last, e.last);
               check("len", frm_len, e.len);
            end
            prev_last_xfer = frm_last;
         end
         if (frm_err) begin
            last_err_cyc = cyc;
            if (err_q.size() == 0) n_unexp++;
            else check("err_code", err_code, err_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      rx_byte  = b;
      rx_valid = 1'b1;
      tick();
      last_strobe_cyc = cyc;
      rx_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_frame(input logic [7:0] fq[$], input int unsigned gap);
      foreach (fq[i]) send_byte(fq[i], gap);
   endtask

   task automatic wait_drain(input string tag);
      int unsigned n = 0;
      while ((exp_q.size() != 0 || err_q.size() != 0 || busy) && n < 3000) begin
         tick();
         n++;
      end
      tick();
      check(tag, 32'(exp_q.size() + err_q.size()) + 32'(busy), 0);
   endtask

   task automatic rand_frame();
      logic [7:0]  fq[$];
      int unsigned kind;
      int unsigned len;
      int unsigned s;
      logic [7:0]  b;
      repeat ($urandom_range(0, 2)) begin
         b = 8'($urandom);
         if (b == 8'hA5) b = 8'h5A;
         send_byte(b, $urandom_range(0, 2));
      end
      kind = $urandom_range(0, 9);
      fq = '{8'hA5};
      if (kind == 0) begin
         len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXLEN + 1, 255);
         fq.push_back(8'(len));
      end else begin
         len = $urandom_range(1, MAXLEN);
         fq.push_back(8'(len));
         s = len;
         for (int i = 0; i < int'(len); i++) begin
            b = 8'($urandom);
            fq.push_back(b);
            s += int'(b);
         end
         b = 8'(s % 256);
         if (kind <= 2) b = b ^ 8'($urandom_range(1, 255));
         fq.push_back(b);
      end
      model_frame(fq);
      foreach (fq[i]) send_byte(fq[i], ($urandom_range(0, 15) == 0) ? T - 1 : $urandom_range(0, 2));
      wait_drain("rand_drain");
   endtask

   initial begin
      logic [7:0] fq[$];
      #60000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] fq[$];
      repeat (3) tick();
      check("rst_valid", frm_valid, 0);
      check("rst_err", frm_err, 0);
      check("rst_last", frm_last, 0);
      check("rst_data", frm_data, 0);
      check("rst_len", frm_len, 0);
      check("rst_code", err_code, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      tick();

      // 1: good frame, valid rises the cycle after the checksum strobe
      hold_ready = 1'b1;
      fq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
      model_frame(fq);
      send_frame(fq, 1);
      check("t1_valid_rise", frm_valid, 1);
      check("t1_first_data", frm_data, 8'h11);
      hold_ready = 1'b0;
      wait_drain("t1_drain");

      // 2: bad checksum
      fq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
      model_frame(fq);
      send_frame(fq, 0);
      wait_drain("t2_drain");
      repeat (3) tick();
      check("t2_code_hold", err_code, C_CHK);
      check("t2_err_low", frm_err, 0);

      // 3: LEN zero and LEN above max
      fq = '{8'hA5, 8'h00};
      model_frame(fq);
      send_frame(fq, 0);
      wait_drain("t3a_drain");
      check("t3a_idle", busy, 0);
      fq = '{8'hA5, 8'h11};
      model_frame(fq);
      send_frame(fq, 2);
      wait_drain("t3b_drain");
      check("t3b_idle", busy, 0);

      // 4: gap of exactly T-1 idle cycles is accepted, then a real timeout
      fq = '{8'hA5, 8'h01, 8'h42, 8'h43};
      model_frame(fq);
      send_frame(fq, T - 1);
      wait_drain("t4_edge_drain");
      err_q.push_back(C_TMO);
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h10, 0);
      wait_drain("t4_tmo_drain");
      check("t4_tmo_latency", last_err_cyc - last_strobe_cyc, T);
      check("t4_tmo_code", err_code, C_TMO);
      fq = '{8'hA5, 8'h01, 8'h07, 8'h08};
      model_frame(fq);
      send_frame(fq, 1);
      wait_drain("t4_next_drain");

      // 5: stalled sink plus overrun byte during output
      hold_ready = 1'b1;
      tick();
      fq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
      model_frame(fq);
      send_frame(fq, 0);
      tick();
      err_q.push_back(C_OVR);
      send_byte(8'h55, 0);
      repeat (20) tick();
      check("t5_still_valid", frm_valid, 1);
      check("t5_ovr_seen", 32'(err_q.size()), 0);
      hold_ready = 1'b0;
      wait_drain("t5_drain");

      for (int k = 0; k < 40; k++) rand_frame();

      // 6: reset mid-payload, then a good frame
      send_byte(8'hA5, 0);
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_busy_after_rst", busy, 0);
      fq = '{8'hA5, 8'h02, 8'h07, 8'h08, 8'h11};
      model_frame(fq);
      send_frame(fq, 1);
      wait_drain("t6_drain");
`ifdef UART_FRM_STATS_EN
      check("t6_good_cnt", good_cnt, 1);
      check("t6_err_cnt", err_cnt, 0);
`endif

      repeat (5) tick();
      check("unexpected_events", n_unexp, 0);
      check("leftover_expect", 32'(exp_q.size() + err_q.size()), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
